// File: rtl/rob_commit_unit.sv
// Reorder buffer: allocates entries in program order, accepts out-of-order
// completions by index, and retires from the head or flushes on an exception.
module rob_commit_unit #(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_alloc_valid,
   input  logic [4:0]       in_alloc_rd,
   input  logic             in_alloc_write_enable,
   input  logic [31:0]      in_alloc_PC,
   output logic             out_alloc_ready,
   output logic [IDX_W-1:0] out_alloc_idx,
   input  logic             in_complete_valid,
   input  logic [IDX_W-1:0] in_complete_idx,
   input  logic [31:0]      in_complete_data,
   input  logic [2:0]       in_complete_exception_vector,
   input  logic             in_d_cache_stall,
   output logic             out_commit_valid,
   output logic [4:0]       out_commit_rd,
   output logic [31:0]      out_commit_data,
   output logic             out_commit_write_enable,
   output logic             out_exception,
   output logic [2:0]       out_exception_vector,
   output logic [31:0]      out_exception_PC,
   output logic             out_flush,
   output logic             out_full,
   output logic             out_empty,
   output logic [IDX_W:0]   out_count
);

   localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(ENTRIES);

   logic [ENTRIES-1:0] valid_q;
   logic [ENTRIES-1:0] done_q;
   logic [ENTRIES-1:0] we_q;
   logic [4:0]         rd_q   [ENTRIES];
   logic [31:0]        pc_q   [ENTRIES];
   logic [31:0]        data_q [ENTRIES];
   logic [2:0]         vec_q  [ENTRIES];

   logic [IDX_W-1:0]   head_q;
   logic [IDX_W-1:0]   tail_q;
   logic [IDX_W:0]     count_q;

   logic               commit_valid_p1;
   logic [4:0]         commit_rd_p1;
   logic [31:0]        commit_data_p1;
   logic               commit_we_p1;
   logic               exception_p1;
   logic [2:0]         exc_vec_p1;
   logic [31:0]        exc_pc_p1;
   logic               flush_p1;

   logic               alloc_fire;
   logic               complete_hit;
   logic               head_ready;
   logic               retire_fire;
   logic               except_fire;

   assign out_full        = (count_q == FULL_COUNT);
   assign out_empty       = (count_q == '0);
   assign out_count       = count_q;
   assign out_alloc_idx   = tail_q;
   assign out_alloc_ready = !out_full && !in_d_cache_stall && !flush_p1;

   // Commit decisions look only at the head and only at registered state,
   // so a completion becomes retireable one edge after it is sampled.
   assign alloc_fire   = in_alloc_valid && out_alloc_ready;
   assign complete_hit = in_complete_valid && valid_q[in_complete_idx];
   assign head_ready   = valid_q[head_q] && done_q[head_q] && !in_d_cache_stall;
   assign retire_fire  = head_ready && (vec_q[head_q] == 3'd0);
   assign except_fire  = head_ready && (vec_q[head_q] != 3'd0);

   // Control state: an exception at the head empties the buffer and wins
   // over any allocation or completion landing on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         done_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (except_fire) begin
         valid_q <= '0;
         done_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (complete_hit)
            done_q[in_complete_idx] <= 1'b1;
         if (alloc_fire) begin
            valid_q[tail_q] <= 1'b1;
            done_q[tail_q]  <= 1'b0;
            tail_q          <= tail_q + IDX_W'(1);
         end
         if (retire_fire) begin
            valid_q[head_q] <= 1'b0;
            done_q[head_q]  <= 1'b0;
            head_q          <= head_q + IDX_W'(1);
         end
         count_q <= count_q + {{IDX_W{1'b0}}, alloc_fire}
                            - {{IDX_W{1'b0}}, retire_fire};
      end
   end

   // Entry payload carries no reset; valid/done bits qualify every read.
   always_ff @(posedge clk) begin
      if (alloc_fire) begin
         rd_q[tail_q] <= in_alloc_rd;
         we_q[tail_q] <= in_alloc_write_enable;
         pc_q[tail_q] <= in_alloc_PC;
      end
      if (complete_hit) begin
         data_q[in_complete_idx] <= in_complete_data;
         vec_q[in_complete_idx]  <= in_complete_exception_vector;
      end
   end

   // Stage p1: registered retire / exception strobes
   always_ff @(posedge clk) begin
      if (reset) begin
         commit_valid_p1 <= 1'b0;
         commit_rd_p1    <= '0;
         commit_data_p1  <= '0;
         commit_we_p1    <= 1'b0;
         exception_p1    <= 1'b0;
         exc_vec_p1      <= '0;
         exc_pc_p1       <= '0;
         flush_p1        <= 1'b0;
      end else begin
         commit_valid_p1 <= retire_fire;
         commit_we_p1    <= retire_fire && we_q[head_q];
         exception_p1    <= except_fire;
         flush_p1        <= except_fire;
         if (retire_fire) begin
            commit_rd_p1   <= rd_q[head_q];
            commit_data_p1 <= data_q[head_q];
         end
         if (except_fire) begin
            exc_vec_p1 <= vec_q[head_q];
            exc_pc_p1  <= pc_q[head_q];
         end
      end
   end

   assign out_commit_valid        = commit_valid_p1;
   assign out_commit_rd           = commit_rd_p1;
   assign out_commit_data         = commit_data_p1;
   assign out_commit_write_enable = commit_we_p1;
   assign out_exception           = exception_p1;
   assign out_exception_vector    = exc_vec_p1;
   assign out_exception_PC        = exc_pc_p1;
   assign out_flush               = flush_p1;

endmodule
